// File: rtl/regbank_pkg.sv
// Shared constants and state encoding for the register bank write path.
package regbank_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 5;
  localparam int NUM_REGS     = 2 ** ADDR_WIDTH;
  localparam int STARVE_LIMIT = 4;

  // r0 is hardwired to zero in the bank; writes to it are dropped.
  localparam logic [ADDR_WIDTH-1:0] R0_ADDR = '0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } sched_state_e;

endpackage

// File: rtl/regbank_write_sched_starve_ctr.sv
// Saturating refusal counter used to force a starved AUX request through.
module regbank_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/regbank_write_sched.sv
// Write-port scheduler: clears the bank after reset, then arbitrates WB (priority)
// against AUX with an anti-starvation override. Write outputs are registered.
module regbank_write_sched
  import regbank_pkg::*;
#(
  parameter int DATA_WIDTH   = regbank_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = regbank_pkg::ADDR_WIDTH,
  parameter int STARVE_LIMIT = regbank_pkg::STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_req,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_stall,
  input  logic                  aux_valid,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0] aux_data,
  output logic                  aux_ready,
  output logic                  rb_we,
  output logic [ADDR_WIDTH-1:0] rb_waddr,
  output logic [DATA_WIDTH-1:0] rb_wdata,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

  sched_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  rb_we_q, rb_we_d;
  logic [ADDR_WIDTH-1:0] rb_waddr_q, rb_waddr_d;
  logic [DATA_WIDTH-1:0] rb_wdata_q, rb_wdata_d;

  logic starve_inc, starve_clr, at_limit;
  logic force_aux, wb_go, aux_go;

  regbank_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (starve_inc),
    .clr_i     (starve_clr),
    .at_limit_o(at_limit)
  );

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    rb_we_d    = 1'b0;
    rb_waddr_d = rb_waddr_q;
    rb_wdata_d = rb_wdata_q;
    wb_stall   = 1'b1;
    aux_ready  = 1'b0;
    force_aux  = 1'b0;
    wb_go      = 1'b0;
    aux_go     = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b1;

    unique case (state_q)
      ST_CLEAR: begin
        rb_we_d    = 1'b1;
        rb_waddr_d = clr_cnt_q;
        rb_wdata_d = '0;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        force_aux  = at_limit && aux_valid;
        aux_ready  = aux_valid && (!wb_req || force_aux);
        wb_stall   = wb_req && force_aux;
        wb_go      = wb_req && !force_aux;
        aux_go     = aux_valid && (!wb_req || force_aux);
        starve_inc = aux_valid && !aux_go;
        starve_clr = !aux_valid || aux_go;
        // r0 writes still complete the handshake; only the enable is suppressed.
        if (wb_go) begin
          rb_we_d    = (wb_addr != R0_ADDR);
          rb_waddr_d = wb_addr;
          rb_wdata_d = wb_data;
        end else if (aux_go) begin
          rb_we_d    = (aux_addr != R0_ADDR);
          rb_waddr_d = aux_addr;
          rb_wdata_d = aux_data;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= ZERO_ADDR;
      rb_we_q    <= 1'b0;
      rb_waddr_q <= ZERO_ADDR;
      rb_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      rb_we_q    <= rb_we_d;
      rb_waddr_q <= rb_waddr_d;
      rb_wdata_q <= rb_wdata_d;
    end
  end

  assign rb_we    = rb_we_q;
  assign rb_waddr = rb_waddr_q;
  assign rb_wdata = rb_wdata_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regbank_write_sched.sv
// Self-checking bench for regbank_write_sched: clear sequence, table-driven arbitration, resets.
module tb_regbank_write_sched;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NREGS = 32;

  typedef struct {
    logic          wb_req;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          aux_valid;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_data;
    logic          exp_stall;
    logic          exp_ready;
  } vec_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_req = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          wb_stall;
  logic          aux_valid = 1'b0;
  logic [AW-1:0] aux_addr = '0;
  logic [DW-1:0] aux_data = '0;
  logic          aux_ready;
  logic          rb_we;
  logic [AW-1:0] rb_waddr;
  logic [DW-1:0] rb_wdata;
  logic          busy;

  int errors = 0;
  int checks = 0;
  wr_t sbq[$];
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  vec_t vecs[22];

  regbank_write_sched dut (
    .clk      (clk),
    .rst      (rst),
    .wb_req   (wb_req),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_stall (wb_stall),
    .aux_valid(aux_valid),
    .aux_addr (aux_addr),
    .aux_data (aux_data),
    .aux_ready(aux_ready),
    .rb_we    (rb_we),
    .rb_waddr (rb_waddr),
    .rb_wdata (rb_wdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                              input logic es, input logic er);
    vec_t v;
    v.wb_req = wr; v.wb_addr = wa; v.wb_data = wd;
    v.aux_valid = av; v.aux_addr = aa; v.aux_data = ad;
    v.exp_stall = es; v.exp_ready = er;
    return v;
  endfunction

  // Drives n clear cycles with both requesters active; expects writes 0..n-1 of zero.
  task automatic run_clear(input int n);
    wb_req = 1'b1; wb_addr = 5'd4; wb_data = 32'h1111_1111;
    aux_valid = 1'b1; aux_addr = 5'd6; aux_data = 32'h2222_2222;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("clr%0d busy", k), busy, 1'b1);
      chk($sformatf("clr%0d wb_stall", k), wb_stall, 1'b1);
      chk($sformatf("clr%0d aux_ready", k), aux_ready, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("clr%0d rb_we", k), rb_we, 1'b1);
      chk($sformatf("clr%0d rb_waddr", k), rb_waddr, k[AW-1:0]);
      chk($sformatf("clr%0d rb_wdata", k), rb_wdata, '0);
    end
    if (n == NREGS) begin
      chk("clear_done busy", busy, 1'b0);
      chk("clear_done wb_stall", wb_stall, 1'b0);
      chk("clear_done aux_ready", aux_ready, 1'b0);
      wb_req = 1'b0;
      aux_valid = 1'b0;
      last_addr = 5'd31;
      last_data = '0;
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    wr_t w, got;
    @(negedge clk);
    wb_req = v.wb_req; wb_addr = v.wb_addr; wb_data = v.wb_data;
    aux_valid = v.aux_valid; aux_addr = v.aux_addr; aux_data = v.aux_data;
    #1;
    chk($sformatf("v%0d wb_stall", idx), wb_stall, v.exp_stall);
    chk($sformatf("v%0d aux_ready", idx), aux_ready, v.exp_ready);
    if (v.wb_req && !v.exp_stall) begin
      w.we = (v.wb_addr != 0); w.addr = v.wb_addr; w.data = v.wb_data;
    end else if (v.aux_valid && v.exp_ready) begin
      w.we = (v.aux_addr != 0); w.addr = v.aux_addr; w.data = v.aux_data;
    end else begin
      w.we = 1'b0; w.addr = last_addr; w.data = last_data;
    end
    last_addr = w.addr;
    last_data = w.data;
    sbq.push_back(w);
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL v%0d scoreboard: queue empty, expected one entry", idx);
    end else begin
      got.we = rb_we; got.addr = rb_waddr; got.data = rb_wdata;
      w = sbq.pop_front();
      chk($sformatf("v%0d rb_we", idx), got.we, w.we);
      chk($sformatf("v%0d rb_waddr", idx), got.addr, w.addr);
      chk($sformatf("v%0d rb_wdata", idx), got.data, w.data);
    end
  endtask

  initial begin
    // wb_req wb_addr wb_data | aux_valid aux_addr aux_data | exp_stall exp_ready
    vecs[0]  = mk(1, 7,  32'hDEAD_BEEF, 0, 0, 0,            0, 0);
    vecs[1]  = mk(1, 0,  32'h1234_5678, 0, 0, 0,            0, 0);
    vecs[2]  = mk(0, 0,  0,             0, 0, 0,            0, 0);
    vecs[3]  = mk(1, 20, 32'h1,         1, 3, 32'hA5A5_A5A5, 0, 0);
    vecs[4]  = mk(1, 21, 32'h2,         1, 3, 32'hA5A5_A5A5, 0, 0);
    vecs[5]  = mk(1, 22, 32'h3,         1, 3, 32'hA5A5_A5A5, 0, 0);
    vecs[6]  = mk(1, 23, 32'h4,         1, 3, 32'hA5A5_A5A5, 0, 0);
    vecs[7]  = mk(1, 24, 32'h5,         1, 3, 32'hA5A5_A5A5, 1, 1);
    vecs[8]  = mk(1, 24, 32'h5,         0, 0, 0,            0, 0);
    vecs[9]  = mk(1, 9,  32'h1,         1, 9, 32'h2,        0, 0);
    vecs[10] = mk(0, 0,  0,             1, 9, 32'h2,        0, 1);
    vecs[11] = mk(0, 0,  0,             1, 0, 32'h77,       0, 1);
    vecs[12] = mk(0, 0,  0,             0, 0, 0,            0, 0);
    vecs[13] = mk(0, 0,  0,             1, 31, 32'hFFFF_0000, 0, 1);
    vecs[14] = mk(1, 1,  32'h11,        1, 2, 32'h22,       0, 0);
    vecs[15] = mk(1, 2,  32'h33,        0, 0, 0,            0, 0);
    vecs[16] = mk(1, 3,  32'h44,        1, 4, 32'h55,       0, 0);
    vecs[17] = mk(1, 3,  32'h45,        1, 4, 32'h55,       0, 0);
    vecs[18] = mk(1, 3,  32'h46,        1, 4, 32'h55,       0, 0);
    vecs[19] = mk(1, 3,  32'h47,        1, 4, 32'h55,       0, 0);
    vecs[20] = mk(1, 3,  32'h48,        1, 4, 32'h55,       1, 1);
    vecs[21] = mk(1, 3,  32'h48,        0, 0, 0,            0, 0);

    last_addr = '0;
    last_data = '0;

    #1;
    chk("reset rb_we", rb_we, 1'b0);
    chk("reset rb_waddr", rb_waddr, '0);
    chk("reset rb_wdata", rb_wdata, '0);
    chk("reset busy", busy, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Abort the clear after 10 writes; it must restart from address 0.
    run_clear(10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midclear rb_we", rb_we, 1'b0);
    chk("midclear rb_waddr", rb_waddr, '0);
    chk("midclear busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    run_clear(NREGS);

    for (int i = 0; i < 22; i++) begin
      apply(vecs[i], i);
    end

    // Reset while a WB transfer is being accepted: the write must never appear.
    @(negedge clk);
    wb_req = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFE_F00D;
    aux_valid = 1'b0;
    #1;
    chk("runrst wb_stall", wb_stall, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("runrst rb_we", rb_we, 1'b0);
    chk("runrst busy", busy, 1'b1);
    @(posedge clk); #1;
    chk("runrst lost rb_we", rb_we, 1'b0);
    chk("runrst lost rb_waddr", rb_waddr, '0);
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    run_clear(NREGS);
    apply(vecs[0], 100);
    apply(vecs[2], 101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regbank_write_sched.md
Name: regbank_write_sched

Overview:
- Write-port scheduler for the 32 x 32-bit register bank; drives the bank's single write port (5-bit address feeds the bank's one-hot write-select decoder).
- Shares the port between the pipeline writeback stage (WB, priority) and an auxiliary requester (AUX: multi-cycle mul/div or debug loader) using valid/ready, with an anti-starvation guard.
- After every reset, sequentially clears all registers to zero before accepting traffic.

Parameters:
- DATA_WIDTH, 32, register width.
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH.
- STARVE_LIMIT, 4, consecutive cycles AUX may be refused before it is forced through.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- wb_req  input  1  WB write request.
- wb_addr  input  ADDR_WIDTH  WB destination register.
- wb_data  input  DATA_WIDTH  WB write data.
- wb_stall  output  1  WB request not accepted this cycle; pipeline must hold.
- aux_valid  input  1  AUX write request.
- aux_addr  input  ADDR_WIDTH  AUX destination register.
- aux_data  input  DATA_WIDTH  AUX write data.
- aux_ready  output  1  AUX request accepted this cycle.
- rb_we  output  1  register bank write enable (registered).
- rb_waddr  output  ADDR_WIDTH  register bank write address (registered).
- rb_wdata  output  DATA_WIDTH  register bank write data (registered).
- busy  output  1  clear sequence in progress.

Behaviour:
- States: CLEAR, RUN. rst (any time, including mid-clear or mid-transfer) forces CLEAR asynchronously: clr_cnt=0, starve_cnt=0, rb_we=0, rb_waddr=0, rb_wdata=0, busy=1.
- CLEAR: each cycle register rb_we=1, rb_waddr=clr_cnt, rb_wdata=0; clr_cnt increments. After clr_cnt=NUM_REGS-1 is issued, go to RUN. Clear issues 32 writes on 32 consecutive cycles, addresses 0..31. In CLEAR: wb_stall=1, aux_ready=0. busy deasserts on the first RUN cycle.
- RUN arbitration (combinational outputs):
  - force = (starve_cnt == STARVE_LIMIT) && aux_valid.
  - aux_ready = aux_valid && (!wb_req || force).
  - wb_stall = wb_req && force.
  - WB transfer: wb_req && !wb_stall. AUX transfer: aux_valid && aux_ready. At most one transfer per cycle.
- Write issue: a transfer registers rb_waddr/rb_wdata from the winner on the next edge. Latency is 1 cycle (accept at cycle N, rb_we high during cycle N+1). rb_we=1 only if the winner's address != 0; writes to r0 complete the handshake but are dropped (rb_we=0). With no transfer, rb_we=0 and addr/data hold their previous values.
- starve_cnt: increments, saturating at STARVE_LIMIT, on a RUN cycle with aux_valid && !aux_ready. Clears on an AUX transfer or when aux_valid=0.
- Simultaneous WB and AUX requests to the same address: the winner writes first and the loser later, so the loser's value is final. The order is defined solely by the arbitration rule above.
- AUX must hold addr/data stable while valid && !ready. WB holds while stalled.
- In RUN there are no gaps: back-to-back transfers issue writes on consecutive cycles.

Decomposition:
- Package regbank_pkg: DATA_WIDTH, ADDR_WIDTH, NUM_REGS, default STARVE_LIMIT, state encoding (CLEAR=1'b0, RUN=1'b1), and R0 address constant shared with the register bank and decoder.
- One sub-module: regbank_starve_ctr. It is a saturating counter with inc/clr inputs and an at_limit output, instanced once.

Test Plan:
- Reset release -> busy=1 for 32 cycles; rb_we=1 with rb_waddr 0,1,...,31 and rb_wdata=0; wb_stall=1 throughout. Then busy=0 and wb_stall follows the arbitration rule.
- RUN, wb_req=1, wb_addr=7, wb_data=0xDEADBEEF for one cycle -> wb_stall=0; next cycle rb_we=1, rb_waddr=7, rb_wdata=0xDEADBEEF.
- wb_addr=0, wb_data=0x12345678 -> wb_stall=0; next cycle rb_we=0 (r0 write dropped).
- aux_valid=1 (addr 3, data 0xA5A5A5A5) with wb_req held high for 6 cycles -> aux_ready=0 for 4 cycles. On the 5th cycle aux_ready=1 and wb_stall=1; next cycle rb_waddr=3, rb_wdata=0xA5A5A5A5. The WB write issues one cycle after that.
- wb_req and aux_valid both to addr 9 (WB 0x1, AUX 0x2), starve_cnt=0 -> WB written first (0x1), then AUX (0x2) the following cycle.
- rst asserted on clear cycle 10 and released -> clear restarts at address 0 and runs a full 32 cycles. rst asserted during a RUN transfer -> rb_we drops immediately and the pending write is lost.
